decode_stage: RTL and testbench

- Registered instruction-decode pipeline stage for the RV32-style core.
- Sits between fetch and execute; it is the successor to the purely combinational decoder.
- Decodes all base formats (R, I, LOAD, S, B, U, J, JALR) and latches the results into an ID/EX register with valid/ready handshake.
- Detects load-use hazards and inserts bubbles; supports flush; reports illegal opcodes; counts stalls.

---
 rtl/decode_stage.sv | 217 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered RV32-style instruction decode between fetch and execute.
//   Decodes the base formats into an ID/EX register guarded by a valid/ready handshake.
//   It inserts bubbles on load-use hazards, honours a flush, flags unsupported opcodes
//   and keeps a saturating count of stall cycles.
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready     fetch-side handshake; ir and pc_in are the instruction and its PC
//   flush                 kills the held and the incoming instruction
//   ex_load/ex_rd         execute stage holds a load that writes ex_rd
//   out_valid/out_ready   execute-side handshake
//   op, y_sel, write,     decoded fields: {opcode, funct7, funct3}, operand-2 select,
//   addr_a/b/d, immed     register write enable, rs1/rs2/rd and the sign-extended immediate
//   pc_out, illegal       latched PC and the unsupported-opcode flag
//   stall_cnt             saturating load-use stall counter
module decode_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int PC_W       = 32,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           ir,
  input  logic [PC_W-1:0]       pc_in,
  input  logic                  flush,
  input  logic                  ex_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16:0]           op,
  output logic                  y_sel,
  output logic                  write,
  output logic [REG_ADDR_W-1:0] addr_a,
  output logic [REG_ADDR_W-1:0] addr_b,
  output logic [REG_ADDR_W-1:0] addr_d,
  output logic [XLEN-1:0]       immed,
  output logic [PC_W-1:0]       pc_out,
  output logic                  illegal,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Raw instruction fields.
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [REG_ADDR_W-1:0] rs1, rs2, rd;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign rd     = ir[7 +: REG_ADDR_W];
  assign rs1    = ir[15 +: REG_ADDR_W];
  assign rs2    = ir[20 +: REG_ADDR_W];

  // Combinational decode of the incoming word.
  logic        dec_illegal;
  logic        dec_y_sel;
  logic        dec_wr;
  logic        uses_rs1;
  logic        uses_rs2;
  logic [31:0] dec_imm32;
  logic [6:0]  dec_f7;
  logic [2:0]  dec_f3;

  always_comb begin
    dec_illegal = 1'b0;
    dec_y_sel   = 1'b0;
    dec_wr      = 1'b0;
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    dec_imm32   = 32'd0;
    dec_f7      = 7'd0;
    dec_f3      = funct3;
    case (opcode)
      OPC_R: begin
        dec_y_sel = 1'b1;
        dec_wr    = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        dec_f7    = funct7;
      end
      OPC_I_ALU: begin
        dec_wr    = 1'b1;
        uses_rs1  = 1'b1;
        dec_imm32 = {{20{ir[31]}}, ir[31:20]};
        // Shift-immediates carry their arithmetic/logical selector in funct7.
        if (funct3 == 3'b001 || funct3 == 3'b101) dec_f7 = funct7;
      end
      OPC_LOAD, OPC_JALR: begin
        dec_wr    = 1'b1;
        uses_rs1  = 1'b1;
        dec_imm32 = {{20{ir[31]}}, ir[31:20]};
      end
      OPC_STORE: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        dec_imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      end
      OPC_BRANCH: begin
        dec_y_sel = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        dec_imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      end
      OPC_JAL: begin
        dec_wr    = 1'b1;
        dec_f3    = 3'd0;  // bits 14:12 are immediate here, not a funct3
        dec_imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_wr    = 1'b1;
        dec_f3    = 3'd0;
        dec_imm32 = {ir[31:12], 12'd0};
      end
      default: begin
        // Unsupported opcode still flows downstream, reduced to a harmless form.
        dec_illegal = 1'b1;
        dec_y_sel   = 1'b1;
        dec_f3      = 3'd0;
      end
    endcase
  end

  logic            dec_write;
  logic [XLEN-1:0] dec_immed;

  assign dec_write = dec_wr & (rd != '0);
  assign dec_immed = XLEN'($signed(dec_imm32));

  // Handshake.
  logic out_valid_q;
  logic advance;
  logic hazard;

  assign advance  = !out_valid_q | out_ready;
  assign hazard   = in_valid & ex_load & (ex_rd != '0) &
                    ((uses_rs1 & (rs1 == ex_rd)) | (uses_rs2 & (rs2 == ex_rd)));
  assign in_ready = advance & !hazard & !flush;

  // ID/EX register.
  logic [16:0]           op_q;
  logic                  y_sel_q;
  logic                  write_q;
  logic [REG_ADDR_W-1:0] addr_a_q, addr_b_q, addr_d_q;
  logic [XLEN-1:0]       immed_q;
  logic [PC_W-1:0]       pc_q;
  logic                  illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      op_q        <= '0;
      y_sel_q     <= 1'b0;
      write_q     <= 1'b0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      addr_d_q    <= '0;
      immed_q     <= '0;
      pc_q        <= '0;
      illegal_q   <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (advance && in_valid && in_ready) begin
      out_valid_q <= 1'b1;
      op_q        <= {opcode, dec_f7, dec_f3};
      y_sel_q     <= dec_y_sel;
      write_q     <= dec_write;
      addr_a_q    <= rs1;
      addr_b_q    <= rs2;
      addr_d_q    <= rd;
      immed_q     <= dec_immed;
      pc_q        <= pc_in;
      illegal_q   <= dec_illegal;
    end else if (advance) begin
      out_valid_q <= 1'b0;
    end
  end

  // Stall counter: a stall is a bubble actually inserted for a hazard.
  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (advance && hazard && !flush && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign out_valid = out_valid_q;
  assign op        = op_q;
  assign y_sel     = y_sel_q;
  assign write     = write_q;
  assign addr_a    = addr_a_q;
  assign addr_b    = addr_b_q;
  assign addr_d    = addr_d_q;
  assign immed     = immed_q;
  assign pc_out    = pc_q;
  assign illegal   = illegal_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors for decode_stage with hand-computed expectations.
//   A second instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ir;
  logic [31:0] pc_in;
  logic        flush;
  logic        ex_load;
  logic [4:0]  ex_rd;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] op;
  logic        y_sel;
  logic        write;
  logic [4:0]  addr_a, addr_b, addr_d;
  logic [31:0] immed;
  logic [31:0] pc_out;
  logic        illegal;
  logic [15:0] stall_cnt;

  // Outputs of the narrow-counter instance.
  logic        s_in_ready, s_out_valid, s_y_sel, s_write, s_illegal;
  logic [16:0] s_op;
  logic [4:0]  s_addr_a, s_addr_b, s_addr_d;
  logic [31:0] s_immed, s_pc_out;
  logic [1:0]  s_stall_cnt;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ir(ir),
    .pc_in(pc_in), .flush(flush), .ex_load(ex_load), .ex_rd(ex_rd),
    .out_valid(out_valid), .out_ready(out_ready), .op(op), .y_sel(y_sel),
    .write(write), .addr_a(addr_a), .addr_b(addr_b), .addr_d(addr_d),
    .immed(immed), .pc_out(pc_out), .illegal(illegal), .stall_cnt(stall_cnt)
  );

  decode_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .ir(ir),
    .pc_in(pc_in), .flush(flush), .ex_load(ex_load), .ex_rd(ex_rd),
    .out_valid(s_out_valid), .out_ready(out_ready), .op(s_op), .y_sel(s_y_sel),
    .write(s_write), .addr_a(s_addr_a), .addr_b(s_addr_b), .addr_d(s_addr_d),
    .immed(s_immed), .pc_out(s_pc_out), .illegal(s_illegal), .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, act);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction and let the combinational handshake settle.
  task automatic present(input logic [31:0] w, input logic [31:0] pc);
    in_valid = 1'b1;
    ir       = w;
    pc_in    = pc;
    #1;
  endtask

  localparam logic [31:0] ADDI_NEG1 = 32'hFFF10093;  // addi x1,x2,-1
  localparam logic [31:0] JAL_NEG4  = 32'hFFDFF0EF;  // jal  x1,-4
  localparam logic [31:0] NOP       = 32'h00000013;  // addi x0,x0,0
  localparam logic [31:0] ADD_657   = 32'h00728333;  // add  x6,x5,x7
  // beq x1,x2,-8
  localparam logic [31:0] BEQ_NEG8  = {1'b1, 6'b111111, 5'd2, 5'd1, 3'b000, 4'b1100, 1'b1, 7'b1100011};
  // sw x7,-4(x5)
  localparam logic [31:0] SW_NEG4   = {7'b1111111, 5'd7, 5'd5, 3'b010, 5'b11100, 7'b0100011};
  localparam logic [31:0] ILLEGAL_W = 32'hFFF000FF;  // opcode 1111111, rd=1

  initial begin
    rst = 1'b1; in_valid = 1'b0; ir = '0; pc_in = '0; flush = 1'b0;
    ex_load = 1'b0; ex_rd = '0; out_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_immed", 64'(immed), 64'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // addi x1,x2,-1
    present(ADDI_NEG1, 32'h100);
    check("addi_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("addi_out_valid", 64'(out_valid), 64'd1);
    check("addi_op", 64'(op), 64'({7'b0010011, 7'd0, 3'd0}));
    check("addi_addr_a", 64'(addr_a), 64'd2);
    check("addi_addr_d", 64'(addr_d), 64'd1);
    check("addi_immed", 64'(immed), 64'hFFFFFFFF);
    check("addi_y_sel", 64'(y_sel), 64'd0);
    check("addi_write", 64'(write), 64'd1);
    check("addi_pc_out", 64'(pc_out), 64'h100);

    // jal x1,-4 back to back
    present(JAL_NEG4, 32'h104);
    tick();
    check("jal_immed", 64'(immed), 64'hFFFFFFFC);
    check("jal_write", 64'(write), 64'd1);
    check("jal_addr_d", 64'(addr_d), 64'd1);

    // addi x0,x0,0 : rd==0 suppresses write
    present(NOP, 32'h108);
    tick();
    check("nop_out_valid", 64'(out_valid), 64'd1);
    check("nop_write", 64'(write), 64'd0);

    // beq x1,x2,-8
    present(BEQ_NEG8, 32'h10C);
    tick();
    check("beq_immed", 64'(immed), 64'hFFFFFFF8);
    check("beq_y_sel", 64'(y_sel), 64'd1);
    check("beq_write", 64'(write), 64'd0);

    // sw x7,-4(x5)
    present(SW_NEG4, 32'h110);
    tick();
    check("sw_immed", 64'(immed), 64'hFFFFFFFC);
    check("sw_op", 64'(op), 64'({7'b0100011, 7'd0, 3'b010}));
    check("sw_addr_b", 64'(addr_b), 64'd7);
    check("sw_write", 64'(write), 64'd0);

    // Load-use hazard on x5
    ex_load = 1'b1; ex_rd = 5'd5;
    present(ADD_657, 32'h114);
    check("haz_in_ready", 64'(in_ready), 64'd0);
    tick();
    check("haz_out_valid", 64'(out_valid), 64'd0);
    check("haz_stall_cnt", 64'(stall_cnt), 64'd1);
    ex_load = 1'b0;
    #1;
    check("haz_rel_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("add_out_valid", 64'(out_valid), 64'd1);
    check("add_op", 64'(op), 64'({7'b0110011, 7'd0, 3'd0}));
    check("add_y_sel", 64'(y_sel), 64'd1);
    check("add_addr_d", 64'(addr_d), 64'd6);
    check("add_immed", 64'(immed), 64'd0);

    // Backpressure with a concurrent hazard: nothing moves, nothing counted
    out_ready = 1'b0; ex_load = 1'b1; ex_rd = 5'd2;
    present(ADDI_NEG1, 32'h200);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp%0d_out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("bp%0d_addr_d", i), 64'(addr_d), 64'd6);
      check($sformatf("bp%0d_pc_out", i), 64'(pc_out), 64'h114);
      check($sformatf("bp%0d_stall_cnt", i), 64'(stall_cnt), 64'd1);
    end
    ex_load = 1'b0; out_ready = 1'b1;
    #1;
    check("bp_rel_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("bp_new_addr_d", 64'(addr_d), 64'd1);
    check("bp_new_immed", 64'(immed), 64'hFFFFFFFF);
    check("bp_new_pc_out", 64'(pc_out), 64'h200);

    // Flush with a hazard present: flush wins, no stall counted
    flush = 1'b1; ex_load = 1'b1; ex_rd = 5'd5;
    present(ADD_657, 32'h204);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_stall_cnt", 64'(stall_cnt), 64'd1);
    flush = 1'b0; ex_load = 1'b0;

    // Unsupported opcode
    present(ILLEGAL_W, 32'h300);
    tick();
    check("ill_out_valid", 64'(out_valid), 64'd1);
    check("ill_illegal", 64'(illegal), 64'd1);
    check("ill_write", 64'(write), 64'd0);
    check("ill_y_sel", 64'(y_sel), 64'd1);
    check("ill_immed", 64'(immed), 64'd0);
    check("ill_op", 64'(op), 64'({7'b1111111, 10'd0}));

    // Reset while an instruction is held
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("mrst_immed", 64'(immed), 64'd0);
    check("mrst_illegal", 64'(illegal), 64'd0);
    rst = 1'b0;

    // Five consecutive hazard cycles: wide counter reaches 5, 2-bit one sticks at 3
    ex_load = 1'b1; ex_rd = 5'd5;
    present(ADD_657, 32'h400);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("sat%0d_stall_wide", k), 64'(stall_cnt), 64'(k));
      check($sformatf("sat%0d_stall_narrow", k), 64'(s_stall_cnt), 64'((k > 3) ? 3 : k));
    end
    check("sat_out_valid", 64'(out_valid), 64'd0);
    ex_load = 1'b0; in_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
